// File: rtl/k_and_s_pkg.sv
// Decoded instruction set shared by the K-and-S decoder and control unit.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

endpackage

// File: rtl/control_unit_mc.sv
// K-and-S multi-cycle control unit: programmable RAM wait states, single-step hold, retire counter.
// Latency W+2 (branch/no-op), W+3 (ALU/STORE), 2W+3 (LOAD); only the step hold stalls issue.
module control_unit_mc
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 16,
  parameter bit STEP_EN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    reg_zero,
  input  logic                    reg_neg,
  input  logic                    reg_ov,
  input  logic                    reg_sov,
  input  logic                    dbg_step_mode,
  input  logic                    dbg_step,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    write_reg_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic                    stepping,
  output logic [CNT_W-1:0]        retired_count
);

  localparam int WC_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  typedef enum logic [3:0] {
    S_FETCH,
    S_LATCH_IR,
    S_DECODE,
    S_LOAD_WAIT,
    S_LOAD_WB,
    S_STORE,
    S_ALU_WB,
    S_STEP_HOLD,
    S_HALT
  } state_t;

  state_t          state;
  state_t          after_retire;
  logic [WC_W-1:0] wait_cnt;
  logic            wait_done;
  logic [1:0]      op_q;
  logic            flags_q;
  logic            is_alu;
  logic            is_load;
  logic            is_store;
  logic            is_halt;
  logic            taken;
  logic            alu_flags;
  logic [1:0]      alu_op;
  logic            retire;
  logic            unused_sov;

  assign unused_sov = reg_sov;
  assign wait_done  = (wait_cnt == WC_W'(MEM_WAIT - 1));
  assign is_load    = (decoded_instruction == I_LOAD);
  assign is_store   = (decoded_instruction == I_STORE);
  assign is_halt    = (decoded_instruction == I_HALT);

  always_comb begin
    is_alu    = 1'b0;
    alu_op    = 2'b00;
    alu_flags = 1'b0;
    taken     = 1'b0;
    case (decoded_instruction)
      I_ADD:    begin is_alu = 1'b1; alu_op = 2'b01; alu_flags = 1'b1; end
      I_SUB:    begin is_alu = 1'b1; alu_op = 2'b10; alu_flags = 1'b1; end
      I_AND:    begin is_alu = 1'b1; alu_op = 2'b11; alu_flags = 1'b1; end
      I_OR:     begin is_alu = 1'b1; alu_flags = 1'b1; end
      I_MOVE:   is_alu = 1'b1;
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = reg_zero;
      I_BNZERO: taken = ~reg_zero;
      I_BNEG:   taken = reg_neg;
      I_BNNEG:  taken = ~reg_neg;
      I_BOV:    taken = reg_ov;
      I_BNOV:   taken = ~reg_ov;
      default:  ;
    endcase
  end

  // Anything that does not need a second execution cycle (incl. HALT entry) retires in DECODE.
  assign retire = ((state == S_DECODE) && !(is_load || is_store || is_alu)) ||
                  (state == S_LOAD_WB) || (state == S_STORE) || (state == S_ALU_WB);

  assign after_retire = (STEP_EN && dbg_step_mode) ? S_STEP_HOLD : S_FETCH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      wait_cnt      <= '0;
      retired_count <= '0;
      op_q          <= 2'b00;
      flags_q       <= 1'b0;
    end else begin
      if (retire) retired_count <= retired_count + 1'b1;
      case (state)
        S_FETCH: begin
          if (wait_done) begin
            wait_cnt <= '0;
            state    <= S_LATCH_IR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_LATCH_IR: state <= S_DECODE;
        S_DECODE: begin
          op_q    <= alu_op;
          flags_q <= alu_flags;
          if (is_halt)       state <= S_HALT;
          else if (is_load)  state <= S_LOAD_WAIT;
          else if (is_store) state <= S_STORE;
          else if (is_alu)   state <= S_ALU_WB;
          else               state <= after_retire;
        end
        S_LOAD_WAIT: begin
          if (wait_done) begin
            wait_cnt <= '0;
            state    <= S_LOAD_WB;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_LOAD_WB, S_STORE, S_ALU_WB: state <= after_retire;
        S_STEP_HOLD: if (dbg_step || !dbg_step_mode) state <= S_FETCH;
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    stepping         = 1'b0;
    case (state)
      S_LATCH_IR: begin
        ir_enable = 1'b1;
        pc_enable = 1'b1;
      end
      S_DECODE: begin
        addr_sel = is_load || is_store;
        if (is_alu) begin
          operation = alu_op;
          c_sel     = 1'b1;
        end
        branch    = taken;
        pc_enable = taken;
      end
      S_LOAD_WAIT: addr_sel = 1'b1;
      S_LOAD_WB: begin
        addr_sel         = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      S_ALU_WB: begin
        operation        = op_q;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = flags_q;
      end
      S_STEP_HOLD: stepping = 1'b1;
      S_HALT:      halt = 1'b1;
      default: ;
    endcase
  end

endmodule
